// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller sitting between the PC register,
// the instruction memory and decode.
//
// One memory read per PC value with a single request outstanding. Fetched
// instructions are presented to decode through a one-entry output register.
// A redirect from EX overrides everything: it steers the PC register to the
// word-aligned target, kills the output entry, and marks any request still
// in flight so that its response is thrown away.
//
// Optional feature: define FETCH_CTRL_PERF_EN to add the perf_fetch_cnt and
// perf_stall_cnt counter ports. Without it the block has no counters and
// behaves identically otherwise.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | just out of reset, no request issued yet
// REQ   | presenting a read for pc (held off while decode is blocked)
// WAIT  | request accepted, waiting for imem_rvalid
//
// drop = 1 means the outstanding response belongs to a redirected-away
// path and must be discarded without advancing the PC.

module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h00400000,
   parameter logic [31:0] NOP_INST = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        decode_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_next,
   output logic        pc_stall,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   drop_q;
   logic   drop_d;

   logic   req_acc;
   logic   rsp_hit;
   logic   rsp_load;
   logic   in_flight;

   // Redirect targets are word aligned; the two low bits are ignored.
   logic   redirect_lsb_unused;
   assign redirect_lsb_unused = ^redirect_pc[1:0];

   // Handshake qualifiers shared by the next-state and output logic.
   always_comb begin
      req_acc   = imem_req && imem_ready;
      rsp_hit   = (state_q == S_WAIT) && imem_rvalid;
      rsp_load  = rsp_hit && !drop_q && !redirect_valid;
      in_flight = req_acc || ((state_q == S_WAIT) && !imem_rvalid);
   end

   // State register and drop flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // Next-state logic; a redirect overrides the normal transitions and
   // keeps waiting only if a request is still owed a response.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      if (redirect_valid) begin
         state_d = in_flight ? S_WAIT : S_REQ;
         drop_d  = in_flight;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (req_acc) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state_d = S_REQ;
                  drop_d  = 1'b0;
               end
            end
            default: begin
               state_d = S_IDLE;
               drop_d  = 1'b0;
            end
         endcase
      end
   end

   // Combinational memory request and PC-register control.
   always_comb begin
      imem_addr = pc;
      imem_req  = (state_q == S_REQ) && !(if_valid && decode_stall);
      pc_stall  = 1'b1;
      pc_next   = pc;
      if (redirect_valid) begin
         pc_stall = 1'b0;
         pc_next  = {redirect_pc[31:2], 2'b00};
      end else if (rsp_load) begin
         pc_stall = 1'b0;
         pc_next  = pc + 32'd4;
      end
   end

   // Output register to decode: load on a live response, otherwise drain
   // when decode takes the entry; an empty entry always shows NOP_INST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_pc    <= RESET_PC;
         if_inst  <= NOP_INST;
      end else if (redirect_valid) begin
         if_valid <= 1'b0;
         if_inst  <= NOP_INST;
      end else if (rsp_load) begin
         if_valid <= 1'b1;
         if_pc    <= pc;
         if_inst  <= imem_rdata;
      end else if (!decode_stall) begin
         if_valid <= 1'b0;
         if_inst  <= NOP_INST;
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   // Counters: delivered instructions and REQ cycles blocked by decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= 32'd0;
         perf_stall_cnt <= 32'd0;
      end else begin
         if (rsp_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if ((state_q == S_REQ) && !imem_req) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. The bench plays the PC register and the
// memory itself: every vector states the pc value and memory handshake for
// one cycle together with the hand-computed outputs.

module tb_fetch_ctrl;

   localparam logic [31:0] P   = 32'h00400000;
   localparam logic [31:0] NOP = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        decode_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc_next;
   logic        pc_stall;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .decode_stall   (decode_stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .pc_next        (pc_next),
      .pc_stall       (pc_stall),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic        rv;
      logic [31:0] rpc;
      logic        ds;
      logic        rdy;
      logic        rvl;
      logic [31:0] rdata;
      logic        e_req;
      logic        e_stall;
      logic [31:0] e_next;
      logic        e_ifv;
      logic [31:0] e_ifpc;
      logic [31:0] e_inst;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] a_pc, input logic a_rv, input logic [31:0] a_rpc,
                               input logic a_ds, input logic a_rdy, input logic a_rvl,
                               input logic [31:0] a_rdata, input logic a_req, input logic a_stall,
                               input logic [31:0] a_next, input logic a_ifv,
                               input logic [31:0] a_ifpc, input logic [31:0] a_inst);
      vec_t v;
      v.pc = a_pc; v.rv = a_rv; v.rpc = a_rpc; v.ds = a_ds; v.rdy = a_rdy;
      v.rvl = a_rvl; v.rdata = a_rdata; v.e_req = a_req; v.e_stall = a_stall;
      v.e_next = a_next; v.e_ifv = a_ifv; v.e_ifpc = a_ifpc; v.e_inst = a_inst;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive, check combinational outputs before the edge, then
   // check the registered outputs just after it.
   task automatic run_vec(input string tag, input vec_t v);
      pc             = v.pc;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      decode_stall   = v.ds;
      imem_ready     = v.rdy;
      imem_rvalid    = v.rvl;
      imem_rdata     = v.rdata;
      #1;
      chk({tag, " imem_req"},  {31'd0, imem_req}, {31'd0, v.e_req});
      chk({tag, " imem_addr"}, imem_addr, v.pc);
      chk({tag, " pc_stall"},  {31'd0, pc_stall}, {31'd0, v.e_stall});
      chk({tag, " pc_next"},   pc_next, v.e_next);
      @(posedge clk);
      #1;
      chk({tag, " if_valid"},  {31'd0, if_valid}, {31'd0, v.e_ifv});
      chk({tag, " if_inst"},   if_inst, v.e_inst);
      if (v.e_ifv) chk({tag, " if_pc"}, if_pc, v.e_ifpc);
   endtask

   vec_t tbl[26];
   vec_t post[11];

   initial begin
      //             pc            rv  rpc           ds   rdy  rvl  rdata          req  stl  next          ifv  ifpc          inst
      tbl[0]  = mk(P,            0, 0,            0,   0,   0,   0,             0,   1,   P,            0,   0,            NOP);
      tbl[1]  = mk(P,            0, 0,            0,   1,   0,   0,             1,   1,   P,            0,   0,            NOP);
      tbl[2]  = mk(P,            0, 0,            0,   0,   1,   32'h20080001,  0,   0,   P+4,          1,   P,            32'h20080001);
      tbl[3]  = mk(P+4,          0, 0,            0,   1,   0,   0,             1,   1,   P+4,          0,   0,            NOP);
      tbl[4]  = mk(P+4,          0, 0,            0,   0,   1,   32'h20090002,  0,   0,   P+8,          1,   P+4,          32'h20090002);
      tbl[5]  = mk(P+8,          0, 0,            1,   1,   0,   0,             0,   1,   P+8,          1,   P+4,          32'h20090002);
      tbl[6]  = mk(P+8,          0, 0,            1,   1,   0,   0,             0,   1,   P+8,          1,   P+4,          32'h20090002);
      tbl[7]  = mk(P+8,          0, 0,            0,   1,   0,   0,             1,   1,   P+8,          0,   0,            NOP);
      tbl[8]  = mk(P+8,          1, 32'h00400103, 0,   0,   0,   0,             0,   0,   32'h00400100, 0,   0,            NOP);
      tbl[9]  = mk(32'h00400100, 0, 0,            0,   0,   1,   32'hDEADBEEF,  0,   1,   32'h00400100, 0,   0,            NOP);
      tbl[10] = mk(32'h00400100, 0, 0,            0,   0,   0,   0,             1,   1,   32'h00400100, 0,   0,            NOP);
      tbl[11] = mk(32'h00400100, 0, 0,            0,   1,   0,   0,             1,   1,   32'h00400100, 0,   0,            NOP);
      tbl[12] = mk(32'h00400100, 0, 0,            0,   0,   1,   32'h11111111,  0,   0,   32'h00400104, 1,   32'h00400100, 32'h11111111);
      tbl[13] = mk(32'h00400104, 0, 0,            0,   1,   0,   0,             1,   1,   32'h00400104, 0,   0,            NOP);
      tbl[14] = mk(32'h00400104, 1, 32'h00400200, 0,   0,   1,   32'h22222222,  0,   0,   32'h00400200, 0,   0,            NOP);
      tbl[15] = mk(32'h00400200, 0, 0,            0,   1,   0,   0,             1,   1,   32'h00400200, 0,   0,            NOP);
      tbl[16] = mk(32'h00400200, 0, 0,            0,   0,   1,   32'h33333333,  0,   0,   32'h00400204, 1,   32'h00400200, 32'h33333333);
      tbl[17] = mk(32'h00400204, 1, 32'h00400300, 1,   1,   0,   0,             0,   0,   32'h00400300, 0,   0,            NOP);
      tbl[18] = mk(32'h00400300, 1, 32'h00400400, 0,   1,   0,   0,             1,   0,   32'h00400400, 0,   0,            NOP);
      tbl[19] = mk(32'h00400400, 0, 0,            0,   0,   1,   32'h44444444,  0,   1,   32'h00400400, 0,   0,            NOP);
      tbl[20] = mk(32'h00400400, 0, 0,            0,   1,   0,   0,             1,   1,   32'h00400400, 0,   0,            NOP);
      tbl[21] = mk(32'h00400400, 0, 0,            0,   0,   1,   32'h55555555,  0,   0,   32'h00400404, 1,   32'h00400400, 32'h55555555);
      tbl[22] = mk(32'h00400404, 0, 0,            0,   0,   0,   0,             1,   1,   32'h00400404, 0,   0,            NOP);
      tbl[23] = mk(32'hFFFFFFFC, 0, 0,            0,   1,   0,   0,             1,   1,   32'hFFFFFFFC, 0,   0,            NOP);
      tbl[24] = mk(32'hFFFFFFFC, 0, 0,            0,   0,   1,   32'h66666666,  0,   0,   32'h00000000, 1,   32'hFFFFFFFC, 32'h66666666);
      tbl[25] = mk(32'h00000000, 0, 0,            1,   1,   0,   0,             0,   1,   32'h00000000, 1,   32'hFFFFFFFC, 32'h66666666);

      // Restart after a mid-fetch reset: 3 fetches with 4 decode-blocked REQ cycles.
      post[0]  = mk(P,           0, 0,            0,   0,   0,   0,             0,   1,   P,            0,   0,            NOP);
      post[1]  = mk(P,           0, 0,            0,   1,   0,   0,             1,   1,   P,            0,   0,            NOP);
      post[2]  = mk(P,           0, 0,            0,   0,   1,   32'hAAAA0001,  0,   0,   P+4,          1,   P,            32'hAAAA0001);
      post[3]  = mk(P+4,         0, 0,            1,   1,   0,   0,             0,   1,   P+4,          1,   P,            32'hAAAA0001);
      post[4]  = mk(P+4,         0, 0,            1,   1,   0,   0,             0,   1,   P+4,          1,   P,            32'hAAAA0001);
      post[5]  = mk(P+4,         0, 0,            0,   1,   0,   0,             1,   1,   P+4,          0,   0,            NOP);
      post[6]  = mk(P+4,         0, 0,            0,   0,   1,   32'hAAAA0002,  0,   0,   P+8,          1,   P+4,          32'hAAAA0002);
      post[7]  = mk(P+8,         0, 0,            1,   1,   0,   0,             0,   1,   P+8,          1,   P+4,          32'hAAAA0002);
      post[8]  = mk(P+8,         0, 0,            1,   1,   0,   0,             0,   1,   P+8,          1,   P+4,          32'hAAAA0002);
      post[9]  = mk(P+8,         0, 0,            0,   1,   0,   0,             1,   1,   P+8,          0,   0,            NOP);
      post[10] = mk(P+8,         0, 0,            0,   0,   1,   32'hAAAA0003,  0,   0,   P+12,         1,   P+8,          32'hAAAA0003);

      rst = 1'b1;
      pc = P; redirect_valid = 1'b0; redirect_pc = '0; decode_stall = 1'b0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      @(posedge clk); #1;
      chk("reset imem_req", {31'd0, imem_req}, 32'd0);
      chk("reset pc_stall", {31'd0, pc_stall}, 32'd1);
      chk("reset pc_next",  pc_next, P);
      chk("reset if_valid", {31'd0, if_valid}, 32'd0);
      chk("reset if_pc",    if_pc, P);
      chk("reset if_inst",  if_inst, NOP);
      rst = 1'b0;

      for (int i = 0; i < 26; i++) run_vec($sformatf("v%0d", i), tbl[i]);

      // Accept a request, then reset while its response is on the bus.
      run_vec("pre_rst", mk(32'h12345678, 0, 0, 0, 1, 0, 0, 1, 1, 32'h12345678, 0, 0, NOP));
      pc = 32'h12345678; imem_rvalid = 1'b1; imem_rdata = 32'h77777777; imem_ready = 1'b0;
      #1;
      chk("wait_rsp pc_stall", {31'd0, pc_stall}, 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst imem_req", {31'd0, imem_req}, 32'd0);
      chk("midrst pc_stall", {31'd0, pc_stall}, 32'd1);
      chk("midrst pc_next",  pc_next, 32'h12345678);
      chk("midrst if_valid", {31'd0, if_valid}, 32'd0);
      chk("midrst if_pc",    if_pc, P);
      chk("midrst if_inst",  if_inst, NOP);
`ifdef FETCH_CTRL_PERF_EN
      chk("midrst perf_fetch", perf_fetch_cnt, 32'd0);
      chk("midrst perf_stall", perf_stall_cnt, 32'd0);
`endif
      imem_rvalid = 1'b0; imem_rdata = '0; pc = P;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_vec($sformatf("post%0d", i), post[i]);
`ifdef FETCH_CTRL_PERF_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, 32'd3);
      chk("perf_stall_cnt", perf_stall_cnt, 32'd4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
